mux_ser_ctrl: RTL and testbench

Upstream control stage for the 8-to-1 multiplexer, which this block uses as a parallel-to-serial converter. It accepts an 8-bit word over a valid/ready handshake and holds it on the mux data inputs. It steps the 3-bit select through all eight channels, one per accepted output beat. It forwards the mux output as a serial stream with its own valid/ready/last handshake.

---
 rtl/mux_ser_ctrl_pkg.sv | 26 ++
 rtl/mux_ser_ctrl_sel_counter.sv | 27 ++
 rtl/mux_ser_ctrl.sv | 90 +++++++++
 tb/tb_mux_ser_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_ser_ctrl_pkg.sv
// Shared types and helpers for the mux-based parallel-to-serial control stage.
package mux_ser_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic [SEL_W-1:0] first_sel(input logic msb_first);
        return msb_first ? SEL_W'(DATA_W - 1) : '0;
    endfunction

    function automatic logic [SEL_W-1:0] last_sel(input logic msb_first);
        return msb_first ? '0 : SEL_W'(DATA_W - 1);
    endfunction

    // Step one channel toward the terminal select.
    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] cur,
                                                   input logic msb_first);
        return msb_first ? cur - 1'b1 : cur + 1'b1;
    endfunction

endpackage

// File: rtl/mux_ser_ctrl_sel_counter.sv
// Channel select counter: loads FIRST, steps toward LAST, flags LAST.
module sel_counter
    import mux_ser_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    output logic [SEL_W-1:0] s,
    output logic             term
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s <= first_sel(MSB_FIRST);
        end else if (load) begin
            s <= first_sel(MSB_FIRST);
        end else if (en) begin
            s <= next_sel(s, MSB_FIRST);
        end
    end

    assign term = (s == last_sel(MSB_FIRST));

endmodule

// File: rtl/mux_ser_ctrl.sv
// Holds a word on the external 8:1 mux and walks its select, one channel per
// accepted serial beat, forwarding the mux output as a valid/ready/last stream.
module mux_ser_ctrl
    import mux_ser_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] d,
    output logic [SEL_W-1:0]  s,
    input  logic              mux_o,
    output logic              ser_out,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_last,
    output logic              state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and the producer holds data
    // stable while valid is high and ready is low.

    state_t state, state_nxt;
    logic   term;
    logic   beat;
    logic   load_fire;
    logic   cnt_en;

    sel_counter #(.MSB_FIRST(MSB_FIRST)) u_sel (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_fire),
        .en    (cnt_en),
        .s     (s),
        .term  (term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d <= '0;
        end else if (load_fire) begin
            d <= load_data;
        end
    end

    always_comb begin
        state_nxt  = state;
        beat       = 1'b0;
        load_ready = 1'b0;
        ser_valid  = 1'b0;
        ser_last   = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid  = 1'b1;
                ser_last   = term;
                beat       = ser_ready;
                // The last beat can hand over to the next word in the same edge.
                load_ready = term && ser_ready;
                if (beat && term && !load_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign load_fire = load_valid && load_ready;
    assign cnt_en    = beat && !term;
    assign ser_out   = mux_o;
    assign state_dbg = state;

endmodule

// File: tb/tb_mux_ser_ctrl.sv
// Directed bench: two instances (LSB-first and MSB-first) share stimulus,
// each with a behavioural 8:1 mux closing the d/s -> mux_o loop.
module tb_mux_ser_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load_valid;
    logic [7:0] load_data;
    logic       ser_ready;

    logic       load_ready0, load_ready1;
    logic [7:0] d0, d1;
    logic [2:0] s0, s1;
    logic       mux_o0, mux_o1;
    logic       ser_out0, ser_out1;
    logic       ser_valid0, ser_valid1;
    logic       ser_last0, ser_last1;
    logic       state0, state1;

    int checks = 0;
    int errors = 0;
    logic [7:0] w;
    logic [7:0] exp_q[$];
    logic [7:0] exp_bit;
    int beats;

    always #5 clk = ~clk;

    assign mux_o0 = d0[s0];
    assign mux_o1 = d1[s1];

    mux_ser_ctrl #(.MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready0),
        .load_data(load_data), .d(d0), .s(s0), .mux_o(mux_o0), .ser_out(ser_out0),
        .ser_valid(ser_valid0), .ser_ready(ser_ready), .ser_last(ser_last0),
        .state_dbg(state0)
    );

    mux_ser_ctrl #(.MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready1),
        .load_data(load_data), .d(d1), .s(s1), .mux_o(mux_o1), .ser_out(ser_out1),
        .ser_valid(ser_valid1), .ser_ready(ser_ready), .ser_last(ser_last1),
        .state_dbg(state1)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; load_valid = 1'b0; load_data = 8'h00; ser_ready = 1'b0;
        tick(); tick();
        #1;
        chk("rst_ready0", 8'(load_ready0), 8'd1);
        chk("rst_valid0", 8'(ser_valid0), 8'd0);
        chk("rst_last0", 8'(ser_last0), 8'd0);
        chk("rst_s0", 8'(s0), 8'd0);
        chk("rst_s1", 8'(s1), 8'd7);
        chk("rst_d0", d0, 8'h00);
        chk("rst_state0", 8'(state0), 8'd0);
        rst_n = 1'b1;

        // One word on both instances; A5 reads the same either direction.
        tick();
        w = 8'hA5;
        load_valid = 1'b1; load_data = w; ser_ready = 1'b1;
        tick();
        load_valid = 1'b0; load_data = 8'h00;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("w1_s0", 8'(s0), 8'(k));
            chk("w1_out0", 8'(ser_out0), 8'(w[k]));
            chk("w1_valid0", 8'(ser_valid0), 8'd1);
            chk("w1_last0", 8'(ser_last0), 8'(k == 7));
            chk("w1_ready0", 8'(load_ready0), 8'(k == 7));
            chk("w1_s1", 8'(s1), 8'(7 - k));
            chk("w1_out1", 8'(ser_out1), 8'(w[7-k]));
            chk("w1_last1", 8'(ser_last1), 8'(k == 7));
            tick();
        end
        #1;
        chk("w1_idle_valid0", 8'(ser_valid0), 8'd0);
        chk("w1_idle_ready0", 8'(load_ready0), 8'd1);
        chk("w1_idle_s0", 8'(s0), 8'd7);
        chk("w1_idle_d0", d0, 8'hA5);
        chk("w1_idle_valid1", 8'(ser_valid1), 8'd0);
        chk("w1_idle_s1", 8'(s1), 8'd0);

        // Backpressure at s=2 for three cycles.
        w = 8'h3C;
        load_valid = 1'b1; load_data = w; ser_ready = 1'b1;
        tick();
        load_valid = 1'b0; load_data = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) begin
                ser_ready = 1'b0;
                for (int h = 0; h < 3; h++) begin
                    #1;
                    chk("bp_hold_s0", 8'(s0), 8'd2);
                    chk("bp_hold_d0", d0, w);
                    chk("bp_hold_out0", 8'(ser_out0), 8'(w[2]));
                    chk("bp_hold_valid0", 8'(ser_valid0), 8'd1);
                    chk("bp_hold_ready0", 8'(load_ready0), 8'd0);
                    tick();
                end
                ser_ready = 1'b1;
            end
            #1;
            chk("bp_s0", 8'(s0), 8'(k));
            chk("bp_out0", 8'(ser_out0), 8'(w[k]));
            chk("bp_last0", 8'(ser_last0), 8'(k == 7));
            tick();
        end
        #1;
        chk("bp_idle_valid0", 8'(ser_valid0), 8'd0);

        // Back-to-back FF then 00 with no bubble.
        load_valid = 1'b1; load_data = 8'hFF; ser_ready = 1'b1;
        tick();
        load_data = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) load_valid = 1'b0;
            #1;
            chk("b2b_valid0", 8'(ser_valid0), 8'd1);
            chk("b2b_out0", 8'(ser_out0), 8'(i < 8));
            chk("b2b_ready0", 8'(load_ready0), 8'(i % 8 == 7));
            chk("b2b_last0", 8'(ser_last0), 8'(i % 8 == 7));
            chk("b2b_out1", 8'(ser_out1), 8'(i < 8));
            chk("b2b_valid1", 8'(ser_valid1), 8'd1);
            tick();
        end
        #1;
        chk("b2b_idle_valid0", 8'(ser_valid0), 8'd0);
        chk("b2b_idle_state0", 8'(state0), 8'd0);

        // Load with ser_ready low in IDLE, then ready toggling each cycle.
        w = 8'h6D;
        load_valid = 1'b1; load_data = w; ser_ready = 1'b0;
        tick();
        load_valid = 1'b0;
        chk("tog_loaded_d0", d0, w);
        chk("tog_loaded_s0", 8'(s0), 8'd0);
        for (int k = 0; k < 8; k++) exp_q.push_back(8'(w[k]));
        beats = 0;
        for (int cyc = 0; cyc < 40 && beats < 8; cyc++) begin
            ser_ready = cyc[0];
            #1;
            if (ser_valid0 && ser_ready) begin
                exp_bit = exp_q.pop_front();
                chk("tog_out0", 8'(ser_out0), exp_bit);
                chk("tog_last0", 8'(ser_last0), 8'(beats == 7));
                beats++;
            end
            tick();
        end
        #1;
        chk("tog_beats", 8'(beats), 8'd8);
        chk("tog_idle_valid0", 8'(ser_valid0), 8'd0);
        ser_ready = 1'b1;

        // Reset mid-word at s=4.
        w = 8'h5A;
        load_valid = 1'b1; load_data = w;
        tick();
        load_valid = 1'b0;
        tick(); tick(); tick(); tick();
        #1;
        chk("mid_s0", 8'(s0), 8'd4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid0", 8'(ser_valid0), 8'd0);
        chk("mid_rst_last0", 8'(ser_last0), 8'd0);
        chk("mid_rst_s0", 8'(s0), 8'd0);
        chk("mid_rst_d0", d0, 8'h00);
        chk("mid_rst_s1", 8'(s1), 8'd7);
        chk("mid_rst_ready0", 8'(load_ready0), 8'd1);
        tick();
        rst_n = 1'b1;
        tick();
        w = 8'h81;
        load_valid = 1'b1; load_data = w;
        tick();
        load_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("post_s0", 8'(s0), 8'(k));
            chk("post_out0", 8'(ser_out0), 8'(w[k]));
            chk("post_out1", 8'(ser_out1), 8'(w[7-k]));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
